// File: rtl/core_run_ctrl.sv
// core_run_ctrl: streams a host program into imem, holds the core in reset, then runs it.
// Optional single-step while halted is enabled by defining STEP_EN.
module core_run_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int RST_HOLD   = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               host_start_i,
  input  logic [ADDR_W:0]    host_len_i,
  input  logic               host_valid_i,
  input  logic [INSTR_W-1:0] host_data_i,
  output logic               host_ready_o,
  output logic               imem_we_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic [INSTR_W-1:0] imem_wdata_o,
  input  logic [CNT_W-1:0]   run_cycles_i,
  input  logic               halt_i,
`ifdef STEP_EN
  input  logic               step_i,
`endif
  output logic               core_rst_o,
  output logic               core_run_o,
  output logic [CNT_W-1:0]   cycle_cnt_o,
  output logic [2:0]         state_o,
  output logic               done_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(IMEM_DEPTH);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [ADDR_W:0]    wcnt_q, wcnt_d;
  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   budget_q, budget_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               crst_q, crst_d;
  logic               run_q, run_d;
  logic               done_q, done_d;

  logic [ADDR_W:0]    len_in;
  logic [ADDR_W:0]    wcnt_nxt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;
  logic               term;
  logic               bad_state;
  logic               step_fire;

  assign len_in    = (host_len_i > DEPTH) ? DEPTH : host_len_i;
  assign wcnt_nxt  = wcnt_q + 1'b1;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign accept    = host_valid_i & ready_q;
  assign term      = (budget_q != '0) && (cnt_q == budget_q - 1'b1);
  assign bad_state = (state_q > S_HALT);

`ifdef STEP_EN
  logic step_q;
  assign step_fire = (state_q == S_HALT) & ~host_start_i & step_i & ~step_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) step_q <= 1'b0;
    else       step_q <= step_i;
  end
`else
  assign step_fire = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      wcnt_q   <= '0;
      hcnt_q   <= '0;
      budget_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wcnt_q   <= wcnt_d;
      hcnt_q   <= hcnt_d;
      budget_q <= budget_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    hcnt_d   = hcnt_q;
    budget_d = budget_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (host_start_i) begin
          len_d   = len_in;
          wcnt_d  = '0;
          state_d = (len_in == '0) ? S_HOLD : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wcnt_d = wcnt_nxt;
          if (wcnt_nxt == len_q) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hcnt_q == HOLD_LAST) begin
          state_d  = S_RUN;
          budget_d = run_cycles_i;
          cnt_d    = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (halt_i || term) state_d = S_HALT;
      end
      S_HALT: begin
        if (host_start_i) begin
          len_d   = len_in;
          wcnt_d  = '0;
          state_d = (len_in == '0) ? S_HOLD : S_LOAD;
        end else if (run_q) begin
          // a single-step pulse is accounted for as it retires
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (state_d == S_HOLD && state_q != S_HOLD) hcnt_d = '0;
  end

  always_comb begin
    ready_d = (state_d == S_LOAD);
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == S_LOAD && accept) begin
      we_d    = 1'b1;
      addr_d  = wcnt_q[ADDR_W-1:0];
      wdata_d = host_data_i;
    end
    if (bad_state) begin
      addr_d  = '0;
      wdata_d = '0;
    end
    crst_d = (state_d == S_IDLE) | (state_d == S_LOAD) | (state_d == S_HOLD);
    run_d  = (state_d == S_RUN) | step_fire;
    done_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crst_q  <= 1'b1;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crst_q  <= crst_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign host_ready_o = ready_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign core_rst_o   = crst_q;
  assign core_run_o   = run_q;
  assign cycle_cnt_o  = cnt_q;
  assign state_o      = state_q;
  assign done_o       = done_q;

endmodule
